// File: rtl/booth_mac_accum.sv
// Accumulator stage behind the radix-4 Booth multiplier: registers each product,
// sums a frame into a saturating signed accumulator and hands the result downstream.
module booth_mac_accum #(
    parameter int PW = 24,
    parameter int AW = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_p,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_acc,
    output logic          out_sat,
    output logic [CW-1:0] out_cnt
);

    localparam int SW = AW + 1;

    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_s1_valid;
    logic                 r_s1_last;
    logic signed [PW-1:0] r_s1_p;
    logic signed [AW-1:0] r_acc;
    logic                 r_sat;
    logic [CW-1:0]        r_cnt;
    logic                 w_s1_consume;
    logic [AW:0]          w_sat_res;
    logic [CW-1:0]        w_cnt_inc;

    function automatic logic signed [AW-1:0] sext_p(input logic signed [PW-1:0] p);
        return AW'(p);
    endfunction

    // Result is {clamped, value}; overflow shows up as the two top sum bits disagreeing.
    function automatic logic [AW:0] sat_add(input logic signed [AW-1:0] a,
                                            input logic signed [PW-1:0] p);
        logic signed [AW:0] sum;
        sum = SW'(a) + SW'(p);
        if (!sum[AW] && sum[AW-1])
            return {1'b1, 1'b0, {(AW-1){1'b1}}};
        else if (sum[AW] && !sum[AW-1])
            return {1'b1, 1'b1, {(AW-1){1'b0}}};
        else
            return {1'b0, sum[AW-1:0]};
    endfunction

    assign w_s1_consume = r_s1_valid && (r_state == ACC || (r_state == HOLD && out_ready));
    assign in_ready     = !r_s1_valid || w_s1_consume;
    assign w_sat_res    = sat_add(r_acc, r_s1_p);
    assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ACC;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACC:  if (w_s1_consume && r_s1_last) w_next = HOLD;
            HOLD: if (out_ready) w_next = (w_s1_consume && r_s1_last) ? HOLD : ACC;
            default: w_next = ACC;
        endcase
    end

    always_comb begin
        out_valid = (r_state == HOLD);
        out_acc   = r_acc;
        out_sat   = r_sat;
        out_cnt   = r_cnt;
    end

    // S1 capture and S2 accumulate
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_acc      <= '0;
            r_sat      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (in_valid && in_ready) begin
                r_s1_valid <= 1'b1;
                r_s1_p     <= in_p;
                r_s1_last  <= in_last;
            end else if (w_s1_consume) begin
                r_s1_valid <= 1'b0;
            end

            if (r_state == ACC) begin
                if (w_s1_consume) begin
                    r_acc <= w_sat_res[AW-1:0];
                    r_sat <= r_sat | w_sat_res[AW];
                    r_cnt <= w_cnt_inc;
                end
            end else if (out_ready) begin
                // Next frame's first beat may land on the same edge as the handshake.
                if (w_s1_consume) begin
                    r_acc <= sext_p(r_s1_p);
                    r_sat <= 1'b0;
                    r_cnt <= CW'(1);
                end else begin
                    r_acc <= '0;
                    r_sat <= 1'b0;
                    r_cnt <= '0;
                end
            end
        end
    end

    logic w_unused_s1p;
    assign w_unused_s1p = 1'b0;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Scoreboard bench for booth_mac_accum (AW=24, CW=2 so clamping and count saturation are reachable).
module tb_booth_mac_accum;

    localparam int PW = 24;
    localparam int AW = 24;
    localparam int CW = 2;
    localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (AW - 1));
    localparam longint CMAX = (64'sd1 <<< CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_p;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic          out_sat;
    logic [CW-1:0] out_cnt;

    booth_mac_accum #(.PW(PW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_sat(out_sat), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { longint acc; longint sat; longint cnt; } res_t;

    res_t   sb[$];
    longint m_acc = 0, m_sat = 0, m_cnt = 0;
    int     n_tests = 0, n_fail = 0;
    int     n_acc = 0;
    int     cyc = 0;
    longint got_acc[$], got_sat[$], got_cnt[$];
    int     pop_cyc[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model and output checker, evaluated mid-cycle when inputs are settled.
    always @(negedge clk) begin
        res_t   e;
        longint s;
        cyc++;
        if (rst) begin
            sb.delete();
            m_acc = 0; m_sat = 0; m_cnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_acc", longint'($signed(out_acc)), e.acc);
                    chk("sb_sat", longint'(out_sat), e.sat);
                    chk("sb_cnt", longint'(out_cnt), e.cnt);
                end
                got_acc.push_back(longint'($signed(out_acc)));
                got_sat.push_back(longint'(out_sat));
                got_cnt.push_back(longint'(out_cnt));
                pop_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                n_acc++;
                s = m_acc + longint'($signed(in_p));
                if (s > AMAX) begin m_acc = AMAX; m_sat = 1; end
                else if (s < AMIN) begin m_acc = AMIN; m_sat = 1; end
                else m_acc = s;
                m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
                if (in_last) begin
                    e.acc = m_acc; e.sat = m_sat; e.cnt = m_cnt;
                    sb.push_back(e);
                    m_acc = 0; m_sat = 0; m_cnt = 0;
                end
            end
        end
    end

    task automatic send(input int p, input bit last);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_p     = p[PW-1:0];
        in_last  = last;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) chk("drain_timeout", 0, 1);
    endtask

    task automatic clr();
        got_acc.delete(); got_sat.delete(); got_cnt.delete(); pop_cyc.delete();
    endtask

    task automatic chk_res(input string tag, input int idx, input longint a,
                           input longint s, input longint c);
        if (got_acc.size() <= idx) begin
            chk({tag, "_missing"}, longint'(got_acc.size()), longint'(idx + 1));
        end else begin
            chk({tag, "_acc"}, got_acc[idx], a);
            chk({tag, "_sat"}, got_sat[idx], s);
            chk({tag, "_cnt"}, got_cnt[idx], c);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int a0;
        rst = 1'b1; in_valid = 1'b0; in_p = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_acc", longint'($signed(out_acc)), 0);
        chk("rst_sat", longint'(out_sat), 0);
        chk("rst_cnt", longint'(out_cnt), 0);
        rst = 1'b0;

        // Reset mid-frame, then a single-beat frame with latency check
        repeat (3) send(100, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 1);
        chk("mid_rst_acc", longint'($signed(out_acc)), 0);
        chk("mid_rst_cnt", longint'(out_cnt), 0);
        rst = 1'b0;
        clr();
        send(5, 1'b1);
        @(negedge clk);
        chk("lat_cycle1_valid", longint'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_cycle2_valid", longint'(out_valid), 1);
        drain();
        chk_res("one_beat", 0, 5, 0, 1);

        clr();
        send(4194304, 1'b0); send(-4192256, 1'b0); send(1000, 1'b1);
        drain();
        chk_res("basic", 0, 3048, 0, 3);

        clr();
        send(32'h400000, 1'b0); send(32'h400000, 1'b0); send(-1, 1'b1);
        drain();
        chk_res("sat_pos", 0, 64'h7FFFFE, 1, 3);

        clr();
        send(-4192256, 1'b0); send(-4192256, 1'b0); send(-4192256, 1'b1);
        drain();
        chk_res("sat_neg", 0, -8388608, 1, 3);

        clr();
        repeat (4) send(1, 1'b0);
        send(1, 1'b1);
        drain();
        chk_res("cnt_sat", 0, 5, 0, 3);

        clr();
        send(7, 1'b1); send(-3, 1'b1); send(12, 1'b1);
        drain();
        chk_res("b2b0", 0, 7, 0, 1);
        chk_res("b2b1", 1, -3, 0, 1);
        chk_res("b2b2", 2, 12, 0, 1);
        if (pop_cyc.size() == 3) begin
            chk("b2b_gap01", longint'(pop_cyc[1] - pop_cyc[0]), 1);
            chk("b2b_gap12", longint'(pop_cyc[2] - pop_cyc[1]), 1);
        end else begin
            chk("b2b_count", longint'(pop_cyc.size()), 3);
        end

        // Backpressure: one beat buffered while the result is held
        clr();
        out_ready = 1'b0;
        send(10, 1'b0); send(20, 1'b1);
        a0 = n_acc;
        in_valid = 1'b1; in_p = PW'(3); in_last = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) chk("bp_valid_timeout", 0, 1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_valid", longint'(out_valid), 1);
            chk("bp_acc", longint'($signed(out_acc)), 30);
        end
        chk("bp_extra_beats", longint'(n_acc - a0), 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(4, 1'b1);
        drain();
        chk_res("bp_frame1", 0, 30, 0, 2);
        chk_res("bp_frame2", 1, 7, 0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
